msrv32_fetch_flush_controller: RTL

Sequences instruction fetch for the msrv32 core. It issues requests to instruction memory and tracks the outstanding request's PC. It presents each returned instruction to the instruction decoder and drives the decoder's flush input. On reset, redirects, memory wait states and empty cycles, the decoder sees a NOP (32'h00000013) instead of stale data. It sits between the PC mux and the instruction decoder.

---
 rtl/msrv32_fetch_flush_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/msrv32_fetch_flush_controller.sv
// Instruction fetch sequencer for msrv32: issues imem requests, tracks the
// outstanding PC and hands the decoder either a valid instruction or a NOP/flush.
module msrv32_fetch_flush_controller #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   BOOT_ADDR    = '0,
  parameter int                 FLUSH_CYCLES = 2
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             redirect_in,
  input  logic             stall_in,
  input  logic             ms_riscv32_mp_instr_hready_in,
  input  logic [WIDTH-1:0] ms_riscv32_mp_instr_in,
  output logic [WIDTH-1:0] ms_riscv32_mp_imaddr_out,
  output logic             ms_riscv32_mp_imreq_out,
  output logic [WIDTH-1:0] instr_out,
  output logic             flush_out,
  output logic             instr_valid_out,
  output logic [WIDTH-1:0] fetch_pc_out
);

  localparam logic [WIDTH-1:0] NOP        = WIDTH'(32'h0000_0013);
  localparam logic [3:0]       CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] imaddr, imaddr_nxt;
  logic             pending, pending_nxt;
  logic [WIDTH-1:0] pending_pc, pending_pc_nxt;
  logic [WIDTH-1:0] hold_reg, hold_reg_nxt;
  logic [WIDTH-1:0] hold_pc, hold_pc_nxt;
  logic [3:0]       cnt, cnt_nxt;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state      <= ST_RST;
      imaddr     <= BOOT_ADDR;
      pending    <= 1'b0;
      pending_pc <= '0;
      hold_reg   <= NOP;
      hold_pc    <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      imaddr     <= imaddr_nxt;
      pending    <= pending_nxt;
      pending_pc <= pending_pc_nxt;
      hold_reg   <= hold_reg_nxt;
      hold_pc    <= hold_pc_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    imaddr_nxt      = imaddr;
    pending_nxt     = pending;
    pending_pc_nxt  = pending_pc;
    hold_reg_nxt    = hold_reg;
    hold_pc_nxt     = hold_pc;
    cnt_nxt         = cnt;
    ms_riscv32_mp_imreq_out = 1'b0;
    flush_out       = 1'b1;
    instr_valid_out = 1'b0;
    instr_out       = NOP;
    fetch_pc_out    = hold_pc;

    case (state)
      ST_RST: begin
        fetch_pc_out = '0;
        state_nxt    = ST_RUN;
      end

      ST_RUN: begin
        // Priority: redirect > stall > wait state > accept / first request
        if (redirect_in) begin
          imaddr_nxt  = pc_in;
          pending_nxt = 1'b0;
          cnt_nxt     = CNT_RELOAD;
          state_nxt   = ST_FLUSH;
        end else if (stall_in) begin
          flush_out = 1'b0;
          instr_out = hold_reg;
        end else if (!ms_riscv32_mp_instr_hready_in) begin
          ms_riscv32_mp_imreq_out = 1'b1;
        end else if (pending) begin
          ms_riscv32_mp_imreq_out = 1'b1;
          flush_out       = 1'b0;
          instr_valid_out = 1'b1;
          instr_out       = ms_riscv32_mp_instr_in;
          fetch_pc_out    = pending_pc;
          hold_reg_nxt    = ms_riscv32_mp_instr_in;
          hold_pc_nxt     = pending_pc;
          pending_pc_nxt  = imaddr;
          imaddr_nxt      = pc_in;
        end else begin
          ms_riscv32_mp_imreq_out = 1'b1;
          pending_nxt    = 1'b1;
          pending_pc_nxt = imaddr;
          imaddr_nxt     = pc_in;
        end
      end

      ST_FLUSH: begin
        // A redirect during the bubble restarts the bubble at the new target
        if (redirect_in) begin
          imaddr_nxt = pc_in;
          cnt_nxt    = CNT_RELOAD;
        end else if (cnt == 4'd0) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      default: state_nxt = ST_RST;
    endcase
  end

  assign ms_riscv32_mp_imaddr_out = imaddr;

endmodule
